// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex 7-segment display driver.
//   Scans DIGITS digits, one per REFRESH_DIV clocks, with a load/ready capture
//   handshake that updates the shown value only on frame boundaries, leading-zero
//   suppression and per-digit blinking.
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-high reset
//   value       - 4*DIGITS hex digits, digit 0 in value[3:0]
//   load        - capture request, accepted only while ready=1
//   ready       - high when no capture is pending
//   blank_lz    - leading-zero suppression enable (live)
//   blink_mask  - per-digit blink enable (live)
//   seg         - segments {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   dig_en      - one-hot digit enable, polarity set by ACTIVE_LOW
//   frame_start - one-cycle pulse following each frame wrap
module seg7_scan_driver #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_DIV   = 64,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   output logic                  ready,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_en,
   output logic                  frame_start
);

   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Active-low glyph codes; inverted later for active-high panels.
   function automatic logic [6:0] glyph_al(input logic [3:0] h);
      logic [6:0] g;
      case (h)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h18;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic [VAL_W-1:0]  pend_q, pend_d;
   logic [VAL_W-1:0]  disp_q, disp_d;
   logic              ready_q, ready_d;
   logic              frame_start_q, frame_start_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] dig_en_q, dig_en_d;

   logic              tick_c;
   logic              last_idx_c;
   logic              frame_wrap_c;
   logic              hi_zero_c;
   logic [DIGITS-1:0] lz_vec_c;
   logic [DIGITS-1:0] onehot_c;
   logic [3:0]        cur_digit_c;
   logic              cur_blank_c;
   logic [6:0]        seg_al_c;

   // Scan timing, capture handshake and blink phase.
   always_comb begin
      presc_d       = presc_q;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      pend_d        = pend_q;
      disp_d        = disp_q;
      ready_d       = ready_q;

      tick_c       = (presc_q == PRE_W'(REFRESH_DIV - 1));
      last_idx_c   = (idx_q == IDX_W'(DIGITS - 1));
      frame_wrap_c = tick_c && last_idx_c;

      if (tick_c) begin
         presc_d = '0;
         idx_d   = last_idx_c ? '0 : idx_q + IDX_W'(1);
      end else begin
         presc_d = presc_q + PRE_W'(1);
      end

      frame_start_d = frame_wrap_c;

      // Transfer only from a capture accepted in an earlier cycle, so a load
      // landing on a wrap waits for the next one.
      if (ready_q) begin
         if (load) begin
            pend_d  = value;
            ready_d = 1'b0;
         end
      end else if (frame_wrap_c) begin
         disp_d  = pend_q;
         ready_d = 1'b1;
      end

      if (frame_wrap_c) begin
         if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
         end
      end
   end

   // Digit select, blanking and output encoding.
   always_comb begin
      hi_zero_c   = 1'b1;
      lz_vec_c    = '0;
      onehot_c    = '0;
      cur_digit_c = 4'h0;
      cur_blank_c = 1'b0;

      // Digit i is a leading zero when it and every higher digit are zero.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hi_zero_c   = hi_zero_c && (disp_q[4*i +: 4] == 4'h0);
         lz_vec_c[i] = hi_zero_c && (i != 0);
      end

      for (int i = 0; i < DIGITS; i++) begin
         onehot_c[i] = (idx_q == IDX_W'(i));
         if (idx_q == IDX_W'(i)) begin
            cur_digit_c = disp_q[4*i +: 4];
            cur_blank_c = (blank_lz && lz_vec_c[i]) || (blink_mask[i] && blink_phase_q);
         end
      end

      seg_al_c = cur_blank_c ? 7'h7F : glyph_al(cur_digit_c);
      seg_d    = ACTIVE_LOW ? seg_al_c : ~seg_al_c;
      dig_en_d = ACTIVE_LOW ? ~onehot_c : onehot_c;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         pend_q        <= '0;
         disp_q        <= '0;
         ready_q       <= 1'b1;
         frame_start_q <= 1'b0;
         seg_q         <= SEG_OFF;
         dig_en_q      <= DIG_OFF;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         pend_q        <= pend_d;
         disp_q        <= disp_d;
         ready_q       <= ready_d;
         frame_start_q <= frame_start_d;
         seg_q         <= seg_d;
         dig_en_q      <= dig_en_d;
      end
   end

   assign ready       = ready_q;
   assign frame_start = frame_start_q;
   assign seg         = seg_q;
   assign dig_en      = dig_en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-low and an active-high instance share
// all stimulus; every expectation is given in active-low form and inverted for
// the active-high instance.
module tb_seg7_scan_driver;

   logic        clock;
   logic        reset;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic [3:0]  blink_mask;

   logic        ready_lo, ready_hi;
   logic [6:0]  seg_lo, seg_hi;
   logic [3:0]  dig_en_lo, dig_en_hi;
   logic        fs_lo, fs_hi;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) u_lo (
      .clock(clock), .reset(reset), .value(value), .load(load), .ready(ready_lo),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg_lo), .dig_en(dig_en_lo),
      .frame_start(fs_lo)
   );

   seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)) u_hi (
      .clock(clock), .reset(reset), .value(value), .load(load), .ready(ready_hi),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg_hi), .dig_en(dig_en_hi),
      .frame_start(fs_hi)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] val;
      logic        dbl;
      logic [15:0] val2;
      logic        lz;
      logic [27:0] segs;   // {d3, d2, d1, d0} active-low codes
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [6:0] seg_al, input logic [3:0] en_al);
      chk({tag, " seg_lo"}, 32'(seg_lo), 32'(seg_al));
      chk({tag, " dig_en_lo"}, 32'(dig_en_lo), 32'(en_al));
      chk({tag, " seg_hi"}, 32'(seg_hi), 32'(7'(~seg_al)));
      chk({tag, " dig_en_hi"}, 32'(dig_en_hi), 32'(4'(~en_al)));
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      chk({tag, " ready_lo"}, 32'(ready_lo), 32'(exp));
      chk({tag, " ready_hi"}, 32'(ready_hi), 32'(exp));
   endtask

   task automatic chk_fs(input string tag, input logic exp);
      chk({tag, " frame_start_lo"}, 32'(fs_lo), 32'(exp));
      chk({tag, " frame_start_hi"}, 32'(fs_hi), 32'(exp));
   endtask

   // Called at the frame_start sample; checks the following 16 clocks.
   task automatic check_frame(input string tag, input logic [27:0] segs);
      logic [3:0] en_al;
      int d;
      for (int j = 0; j < 16; j++) begin
         @(negedge clock);
         d     = j / 4;
         en_al = 4'(~(4'b0001 << d));
         check_out($sformatf("%s j%0d", tag, j), segs[7*d +: 7], en_al);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (ready_lo !== 1'b1 && n < 64) begin
         @(negedge clock);
         n++;
      end
      chk({tag, " ready_timeout"}, 32'(ready_lo), 32'(1));
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (fs_lo !== 1'b1 && n < 64);
      chk({tag, " frame_timeout"}, 32'(fs_lo), 32'(1));
   endtask

   // Load, optionally retry while busy, then wait for the transfer at the wrap.
   task automatic do_load(input string tag, input logic [15:0] v, input logic dbl,
                          input logic [15:0] v2);
      chk_ready({tag, " pre"}, 1'b1);
      value = v;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      chk_ready({tag, " busy"}, 1'b0);
      if (dbl) begin
         value = v2;
         load  = 1'b1;
         @(negedge clock);
         load = 1'b0;
         chk_ready({tag, " busy2"}, 1'b0);
      end
      wait_ready(tag);
      chk_fs({tag, " ready_with_fs"}, 1'b1);
      chk({tag, " ready_hi_rise"}, 32'(ready_hi), 32'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h12AF, 1'b0, 16'h0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
      vecs[1] = '{16'h0001, 1'b1, 16'h9999, 1'b0, {7'h40, 7'h40, 7'h40, 7'h79}};
      vecs[2] = '{16'h0050, 1'b0, 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
      vecs[3] = '{16'h0000, 1'b0, 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[4] = '{16'h0100, 1'b0, 16'h0000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
      vecs[5] = '{16'h8000, 1'b0, 16'h0000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}};
      vecs[6] = '{16'hC3B7, 1'b0, 16'h0000, 1'b0, {7'h46, 7'h30, 7'h03, 7'h78}};

      reset      = 1'b1;
      value      = '0;
      load       = 1'b0;
      blank_lz   = 1'b0;
      blink_mask = '0;

      // Reset state
      #1;
      check_out("reset", 7'h7F, 4'hF);
      chk_ready("reset", 1'b1);
      chk_fs("reset", 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // First clock after reset shows digit 0 as "0"
      @(negedge clock);
      check_out("post_reset", 7'h40, 4'hE);

      // Table-driven loads and frame scans
      for (int v = 0; v < 7; v++) begin
         blank_lz = vecs[v].lz;
         do_load($sformatf("vec%0d", v), vecs[v].val, vecs[v].dbl, vecs[v].val2);
         check_frame($sformatf("vec%0d", v), vecs[v].segs);
      end

      // Load accepted in the wrap cycle transfers one frame later
      repeat (15) @(negedge clock);
      value = 16'h4D6E;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      chk_fs("wrapload", 1'b1);
      chk_ready("wrapload", 1'b0);
      check_frame("wrapload_old", vecs[6].segs);
      chk_ready("wrapload_done", 1'b1);
      chk_fs("wrapload_done", 1'b1);
      check_frame("wrapload_new", {7'h19, 7'h21, 7'h02, 7'h06});

      // Reset mid-frame with a capture pending
      value = 16'h9999;
      load  = 1'b1;
      @(negedge clock);
      load = 1'b0;
      repeat (3) @(negedge clock);
      chk_ready("midrst_pending", 1'b0);
      #2 reset = 1'b1;
      #1;
      check_out("midrst_async", 7'h7F, 4'hF);
      chk_ready("midrst_async", 1'b1);
      chk_fs("midrst_async", 1'b0);
      @(negedge clock);
      check_out("midrst_held", 7'h7F, 4'hF);
      reset = 1'b0;
      @(negedge clock);
      check_out("midrst_first", 7'h40, 4'hE);
      wait_frame("midrst");
      chk_ready("midrst_wrap", 1'b1);
      check_frame("midrst_lost", {7'h40, 7'h40, 7'h40, 7'h40});

      // Blinking: phase flips every 2 frame wraps counted from reset
      reset = 1'b1;
      @(negedge clock);
      reset      = 1'b0;
      blink_mask = 4'b0100;
      blank_lz   = 1'b0;
      do_load("blink", 16'h12AF, 1'b0, 16'h0000);
      check_frame("blink_f1", {7'h79, 7'h24, 7'h08, 7'h0E});
      check_frame("blink_f2", {7'h79, 7'h7F, 7'h08, 7'h0E});
      check_frame("blink_f3", {7'h79, 7'h7F, 7'h08, 7'h0E});
      check_frame("blink_f4", {7'h79, 7'h24, 7'h08, 7'h0E});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter BLINK_DIV, default 64: scan frames per blink half-period, minimum 1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and dig_en are active-low; 0 means both are active-high.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port value, input, 4*DIGITS bits: hex digits; digit i is value[4i+3:4i], and digit 0 is least significant.
REQ-008 SHALL have port load, input, 1 bit: request to capture value.
REQ-009 SHALL have port ready, output, 1 bit: high when no capture is pending.
REQ-010 SHALL have port blank_lz, input, 1 bit: enables leading-zero suppression.
REQ-011 SHALL have port blink_mask, input, DIGITS bits: bit i makes digit i blink.
REQ-012 SHALL have port seg, output, 7 bits: segments, with bit6 = g down to bit0 = a.
REQ-013 SHALL have port dig_en, output, DIGITS bits: one-hot digit enable.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each scan frame.

Function
REQ-015 SHALL encode glyphs as follows (active-low hex, 0..F): 40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E. When ACTIVE_LOW=0, each code is bitwise inverted.
REQ-016 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0. A tick occurs in the cycle the count equals REFRESH_DIV-1.
REQ-017 SHALL advance the digit index on each tick, from 0 to DIGITS-1 and then wrapping to 0. A tick that wraps the index to 0 is a frame wrap.
REQ-018 SHALL pulse frame_start high for exactly the one cycle following each frame wrap.
REQ-019 SHALL drive seg and dig_en from registers. Both outputs reflect the digit index with one cycle latency, and exactly one dig_en bit is active at any time outside reset.
REQ-020 SHALL handle load as follows: load=1 with ready=1 copies value into a pending register and drives ready low on the next cycle.
REQ-021 SHALL ignore load while ready=0; the pending contents are unchanged.
REQ-022 SHALL transfer pending to the display register at the next frame wrap and raise ready in the following cycle. Displayed data therefore never changes mid-frame.
REQ-023 SHALL handle a load accepted in the same cycle as a frame wrap by transferring it at the following frame wrap, not the current one.
REQ-024 SHALL toggle blink_phase once every BLINK_DIV frame wraps.
REQ-025 SHALL blank digit i while blink_mask[i]=1 and blink_phase=1.
REQ-026 SHALL, when blank_lz=1, blank digit i (i>0) if digit i and every higher digit are zero. Digit 0 is never suppressed, so a value of 0 shows a single "0".
REQ-027 SHALL drive a blanked digit as seg all-off with its dig_en still active.
REQ-028 SHALL sample blank_lz and blink_mask live each cycle; they do not go through the pending register.

Reset
REQ-029 SHALL, while reset=1, asynchronously force: seg all-off, dig_en all inactive, frame_start=0, ready=1, prescaler=0, digit index=0, blink_phase=0, and the display and pending registers to 0.
REQ-030 SHALL discard any pending capture on reset asserted mid-operation.
REQ-031 SHALL, on the first clock after reset deasserts, show digit 0 with glyph "0".

Verification
REQ-032 SHALL cover a basic scan (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1). Stimulus: load value=16'h12AF. Required: after the next frame wrap, dig_en cycles 1110, 1101, 1011, 0111, each for 4 clocks, with seg 0E, 08, 24, 79 respectively.
REQ-033 SHALL cover the capture handshake. Stimulus: load 16'h0001, then a second load of 16'h9999 while ready=0. Required: the second load is ignored, the display shows 0001, and ready returns to 1 exactly one cycle after the frame wrap.
REQ-034 SHALL cover leading-zero suppression. Stimulus: value=16'h0050 with blank_lz=1. Required: digits 3 and 2 show seg 7F, digit 1 shows 12, digit 0 shows 40. With value=0, only digit 0 shows 40.
REQ-035 SHALL cover blinking (BLINK_DIV=2). Stimulus: blink_mask=4'b0100. Required: digit 2 alternates between its glyph and 7F every 2 frames while the other digits stay steady.
REQ-036 SHALL cover reset mid-operation. Stimulus: assert reset while ready=0 mid-frame. Required: dig_en=1111 and seg=7F immediately without waiting for a clock edge, ready=1, and the pending value is lost.
REQ-037 SHALL cover polarity. Stimulus: rerun REQ-032 with ACTIVE_LOW=0. Required: the inverted codes appear (digit 0 shows seg 71), and dig_en is one-hot high.
